// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the clear/ready state encoding and the per-register clear value.
// Optional build macro: REGFILE_TEST_INIT_EN (bring-up clear values x1..x7 = 1..7).
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    // Clear value written into reg[idx] while the file is being initialised.
    function automatic logic [XLEN_DEF-1:0] rf_init_val(input int unsigned idx);
        logic [XLEN_DEF-1:0] val;
        bit                  test_init;
`ifdef REGFILE_TEST_INIT_EN
        test_init = 1'b1;
`else
        test_init = 1'b0;
`endif
        val = '0;
        if (test_init && idx >= 1 && idx <= 7) begin
            val = XLEN_DEF'(idx);
        end
        return val;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback and the register file. The master side
// drives read addresses and both write ports; the slave side (the file)
// returns read data, ready and the write-collision flag.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) ();

    localparam int AW = $clog2(NREGS);

    logic                ready;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic                wr_collision;

    modport master (
        input  ready, rd_data, wr_collision,
        output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1
    );

    modport slave (
        output ready, rd_data, wr_collision,
        input  rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1
    );

endinterface

// File: rtl/regfile_mp_rd_port.sv
// One combinational read port: masks x0 and the clear phase, then applies
// the write-to-read bypass (WB1 wins over WB0) before falling back to storage.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = $clog2(NREGS_DEF)
) (
    input  logic            active,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] store_data,
    input  logic            we0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wdata0,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    output logic [XLEN-1:0] data
);

    // Zero while clearing or for x0; otherwise newest in-flight write, else storage.
    always_comb begin
        data = '0;
        if (active && addr != '0) begin
            if (we1 && waddr1 == addr) begin
                data = wdata1;
            end else if (we0 && waddr0 == addr) begin
                data = wdata0;
            end else begin
                data = store_data;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD bypassed read ports, two write
// ports (WB1 has priority), a post-reset sequential clear and a registered
// same-address write-collision flag.
// Optional build macro: REGFILE_TEST_INIT_EN (bring-up clear values and a
// simulation message for every committed write).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NREGS);

    if (NREGS < 4 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be a power of two and at least 4");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_mp: NRD must be between 1 and 4");
    end

    rf_state_e           state;
    logic [AW-1:0]       clr_idx;
    logic                ready_q;
    logic                collision_q;
    logic [XLEN-1:0]     regs [NREGS];
    logic [NRD*XLEN-1:0] rd_data_w;
    logic                active;
    logic                same_addr;
    logic                wr0_commit;
    logic                wr1_commit;

    assign active     = (state == RF_READY);
    assign same_addr  = bus.we0 && bus.we1 && (bus.waddr0 == bus.waddr1);
    assign wr1_commit = active && bus.we1 && (bus.waddr1 != '0);
    assign wr0_commit = active && bus.we0 && (bus.waddr0 != '0) && !same_addr;

    // Clear sequencer: walk every register once, then sit in READY until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else if (state == RF_CLEAR) begin
            if (clr_idx == AW'(NREGS - 1)) begin
                state   <= RF_READY;
                ready_q <= 1'b1;
            end else begin
                clr_idx <= clr_idx + AW'(1);
            end
        end
    end

    // Flag a same-address (nonzero) double write for exactly the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= active && same_addr && (bus.waddr1 != '0);
        end
    end

    // Storage: clear writes while initialising, arbitrated writeback afterwards.
    always_ff @(posedge clk) begin
        if (!active) begin
            regs[clr_idx] <= XLEN'(rf_init_val(32'(clr_idx)));
        end else begin
            if (wr0_commit) begin
                regs[bus.waddr0] <= bus.wdata0;
            end
            if (wr1_commit) begin
                regs[bus.waddr1] <= bus.wdata1;
            end
        end
    end

`ifdef REGFILE_TEST_INIT_EN
    // Bring-up trace of every committed write.
    always_ff @(posedge clk) begin
        if (wr0_commit) begin
            $display("regfile_mp: port 0 wrote x%0d = 0x%0h", bus.waddr0, bus.wdata0);
        end
        if (wr1_commit) begin
            $display("regfile_mp: port 1 wrote x%0d = 0x%0h", bus.waddr1, bus.wdata1);
        end
    end
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rd_port (
            .active     (active),
            .addr       (bus.rd_addr[k*AW +: AW]),
            .store_data (regs[bus.rd_addr[k*AW +: AW]]),
            .we0        (bus.we0),
            .waddr0     (bus.waddr0),
            .wdata0     (bus.wdata0),
            .we1        (bus.we1),
            .waddr1     (bus.waddr1),
            .wdata1     (bus.wdata1),
            .data       (rd_data_w[k*XLEN +: XLEN])
        );
    end

    assign bus.rd_data      = rd_data_w;
    assign bus.ready        = ready_q;
    assign bus.wr_collision = collision_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the stimulus process drives directed
// vectors and queues hand-computed expectations; a monitor on the falling
// edge pops and compares them against the live outputs.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_RDY  = 2;
    localparam int K_COLL = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_fail;
    exp_t sbq[$];
    exp_t mon_e;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Value a register holds right after the clear sequence.
    function automatic logic [63:0] exp_init(input int i);
`ifdef REGFILE_TEST_INIT_EN
        return (i >= 1 && i <= 7) ? 64'(i) : 64'd0;
`else
        return (i >= 0) ? 64'd0 : 64'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                                  input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                                  input logic [4:0] r0, input logic [4:0] r1);
        bus.we0     = w0;
        bus.waddr0  = a0;
        bus.wdata0  = d0;
        bus.we1     = w1;
        bus.waddr1  = a1;
        bus.wdata1  = d1;
        bus.rd_addr = {r1, r0};
    endtask

    task automatic push_exp(input int kind, input logic [63:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [63:0] act;
        case (e.kind)
            K_RD0:   act = bus.rd_data[63:0];
            K_RD1:   act = bus.rd_data[127:64];
            K_RDY:   act = {63'd0, bus.ready};
            default: act = {63'd0, bus.wr_collision};
        endcase
        n_vec++;
        if (act !== e.exp) begin
            n_fail++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, e.cyc, act, e.exp);
        end
    endtask

    // Monitor: compare every queued expectation belonging to this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            check_output(mon_e);
        end
    end

    // Walk a clear sequence just after rst release; optionally attempt a
    // (to-be-dropped) double write at clear cycle drop_cyc.
    task automatic run_clear(input int n, input int drop_cyc, input logic [4:0] drop_addr);
        apply_stimulus(0, 0, 0, 0, 0, 0, drop_addr, 5'd5);
        push_exp(K_RDY, 0, "clear_ready_c0");
        push_exp(K_RD0, 0, "clear_rd0_c0");
        push_exp(K_COLL, 0, "clear_coll_c0");
        for (int i = 1; i <= n; i++) begin
            step();
            if (i == drop_cyc) begin
                apply_stimulus(1, drop_addr, 64'h55, 1, drop_addr, 64'h66, drop_addr, 5'd5);
            end else begin
                apply_stimulus(0, 0, 0, 0, 0, 0, drop_addr, 5'd5);
            end
            push_exp(K_RDY, (i == NREGS) ? 64'd1 : 64'd0, "clear_ready");
            push_exp(K_COLL, 0, "clear_coll");
            if (i < NREGS) begin
                push_exp(K_RD0, 0, "clear_rd0_masked");
                push_exp(K_RD1, 0, "clear_rd1_masked");
            end else begin
                push_exp(K_RD0, exp_init(int'(drop_addr)), "post_clear_dropped_write");
                push_exp(K_RD1, exp_init(5), "post_clear_x5");
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        cyc    = 0;
        rst    = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd5, 5'd5);
        step();
        step();
        push_exp(K_RDY, 0, "reset_ready");
        push_exp(K_COLL, 0, "reset_coll");
        push_exp(K_RD0, 0, "reset_rd0");
        step();
        rst = 1'b1;
        run_clear(NREGS, 5, 5'd5);

        // Bypass then storage read of a WB0 write.
        step();
        apply_stimulus(1, 5'd3, 64'hAAAA, 0, 0, 0, 5'd3, 5'd0);
        push_exp(K_RD0, 64'hAAAA, "bypass_wb0_x3");
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        push_exp(K_RD0, 64'hAAAA, "storage_x3");

        // Same-address collision on x9.
        step();
        apply_stimulus(1, 5'd9, 64'h11, 1, 5'd9, 64'h22, 5'd9, 5'd9);
        push_exp(K_RD0, 64'h22, "collision_bypass_rd0");
        push_exp(K_RD1, 64'h22, "collision_bypass_rd1");
        push_exp(K_COLL, 0, "collision_flag_same_cycle");
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd9, 5'd3);
        push_exp(K_RD0, 64'h22, "collision_storage_x9");
        push_exp(K_RD1, 64'hAAAA, "storage_x3_again");
        push_exp(K_COLL, 1, "collision_flag_pulse");
        step();
        push_exp(K_COLL, 0, "collision_flag_clears");
        push_exp(K_RD0, 64'h22, "collision_x9_held");

        // Writes to x0 on both ports: discarded, never bypassed, no collision.
        step();
        apply_stimulus(1, 5'd0, 64'h1234, 1, 5'd0, 64'hFFFF, 5'd0, 5'd0);
        push_exp(K_RD0, 0, "x0_write_rd0");
        push_exp(K_RD1, 0, "x0_write_rd1");
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        push_exp(K_RD1, 0, "x0_after_write");
        push_exp(K_COLL, 0, "x0_no_collision");
        step();
        push_exp(K_RD1, 0, "x0_later");

        // Parallel writes to different registers.
        step();
        apply_stimulus(1, 5'd4, 64'h44, 1, 5'd12, 64'hCC, 5'd4, 5'd12);
        push_exp(K_RD0, 64'h44, "parallel_bypass_x4");
        push_exp(K_RD1, 64'hCC, "parallel_bypass_x12");
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd4, 5'd12);
        push_exp(K_RD0, 64'h44, "parallel_storage_x4");
        push_exp(K_RD1, 64'hCC, "parallel_storage_x12");
        push_exp(K_COLL, 0, "parallel_no_collision");

        // Cross-port bypass: WB1 feeds read port 0, WB0 feeds read port 1.
        step();
        apply_stimulus(1, 5'd4, 64'h4444, 1, 5'd3, 64'h3333, 5'd3, 5'd4);
        push_exp(K_RD0, 64'h3333, "cross_bypass_wb1");
        push_exp(K_RD1, 64'h4444, "cross_bypass_wb0");
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
        push_exp(K_RD0, 64'h3333, "cross_storage_x3");
        push_exp(K_RD1, 64'h4444, "cross_storage_x4");

        // Reset while READY, then a reset pulse part-way through the clear.
        step();
        rst = 1'b0;
        push_exp(K_RDY, 0, "async_reset_ready");
        push_exp(K_RD0, 0, "async_reset_rd0");
        push_exp(K_RD1, 0, "async_reset_rd1");
        step();
        step();
        rst = 1'b1;
        run_clear(10, 0, 5'd3);
        step();
        rst = 1'b0;
        push_exp(K_RDY, 0, "midclear_reset_ready");
        step();
        rst = 1'b1;
        run_clear(NREGS, 5, 5'd7);

        // Contents written before the resets must have been cleared.
        step();
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd12);
        push_exp(K_RD0, exp_init(3), "recleared_x3");
        push_exp(K_RD1, exp_init(12), "recleared_x12");

        step();
        step();
        if (sbq.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
